vedic_pp_combine_pipe: RTL

- Pipelined final stage of the 32x32 Vedic multiplier.
- Consumes the four 32-bit partial products from the 16x16 Vedic sub-multipliers and reduces them to the 64-bit product using 32-bit ripple-carry additions.
- Two register stages with valid/ready flow control.
- Sits between the 16x16 partial-product array and the multiplier's result port.

---
 rtl/vedic_pkg.sv | 29 ++
 rtl/vedic_pp_adder.sv | 30 +++
 rtl/vedic_pp_combine_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vedic_pkg.sv
// Shared widths and the 16-bit ripple-carry block for the Vedic multiplier.
package vedic_pkg;

    localparam int PP_W   = 32;
    localparam int HALF_W = 16;
    localparam int PROD_W = 64;

    typedef struct packed {
        logic              cout;
        logic [HALF_W-1:0] sum;
    } add_res_t;

    // Bit-serial ripple-carry add of one HALF_W slice.
    function automatic add_res_t add_w_carry(input logic [HALF_W-1:0] a,
                                             input logic [HALF_W-1:0] b,
                                             input logic              cin);
        add_res_t r;
        logic     c;
        c     = cin;
        r.sum = '0;
        for (int i = 0; i < HALF_W; i++) begin
            r.sum[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r.cout = c;
        return r;
    endfunction

endpackage

// File: rtl/vedic_pp_adder.sv
// Combinational W-bit adder chained from HALF_W ripple-carry blocks.
module vedic_pp_adder
    import vedic_pkg::*;
#(
    parameter int W = PP_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int NBLK = W / HALF_W;

    // Each block's carry out feeds the next block's carry in.
    always_comb begin : chain
        add_res_t r;
        logic     c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < NBLK; i++) begin
            r = add_w_carry(a[i*HALF_W +: HALF_W], b[i*HALF_W +: HALF_W], c);
            sum[i*HALF_W +: HALF_W] = r.sum;
            c = r.cout;
        end
        cout = c;
    end

endmodule

// File: rtl/vedic_pp_combine_pipe.sv
// Two-stage valid/ready pipeline that folds the four 16x16 partial products
// into the 64-bit product of the 32x32 Vedic multiplier.
module vedic_pp_combine_pipe
    import vedic_pkg::*;
#(
    parameter int W = PP_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   q0,
    input  logic [W-1:0]   q1,
    input  logic [W-1:0]   q2,
    input  logic [W-1:0]   q3,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic [15:0]    done_count
);

    localparam int H = W / 2;

    logic [2:1]     vld_pipe;      // [1] = stage 1, [2] = stage 2
    logic           adv2, ld1, ld2;

    logic [W:0]     s1_sum;        // q1 + q2 with its carry
    logic [W-1:0]   q0_r, q3_r;
    logic [2*W-1:0] p_r;

    logic [W-1:0]   s1_add;
    logic           s1_c;
    logic [W-1:0]   t_lo;
    logic           t_c;
    logic [W:0]     t;
    logic [W-1:0]   hi_sum;
    logic           hi_cout_unused;
    logic [2*W-1:0] p_nxt;

    // Ready chain: stage 2 frees when empty or popped, stage 1 frees when
    // empty or when it can move into stage 2. No skid buffer.
    assign adv2     = !vld_pipe[2] | out_ready;
    assign in_ready = !vld_pipe[1] | adv2;
    assign ld1      = in_valid & in_ready;
    assign ld2      = adv2 & vld_pipe[1];

    assign out_valid = vld_pipe[2];
    assign busy      = |vld_pipe;
    assign product   = p_r;

    vedic_pp_adder #(.W(W)) u_s1 (
        .a   (q1),
        .b   (q2),
        .cin (1'b0),
        .sum (s1_add),
        .cout(s1_c)
    );

    // Middle column: cross terms plus the upper half of al*bl.
    vedic_pp_adder #(.W(W)) u_t (
        .a   (s1_sum[W-1:0]),
        .b   ({{H{1'b0}}, q0_r[W-1:H]}),
        .cin (1'b0),
        .sum (t_lo),
        .cout(t_c)
    );

    // The full sum fits in W+1 bits, so s1_sum[W] and t_c are never both set.
    assign t = {s1_sum[W] ^ t_c, t_lo};

    // Upper word: ah*bh plus the carry-out column of the middle sum.
    // Real partial products never overflow here, so the carry is dropped.
    vedic_pp_adder #(.W(W)) u_hi (
        .a   (q3_r),
        .b   ({{(W-H-1){1'b0}}, t[W:H]}),
        .cin (1'b0),
        .sum (hi_sum),
        .cout(hi_cout_unused)
    );

    assign p_nxt = {hi_sum, t[H-1:0], q0_r[H-1:0]};

    // Valid chain: a stage clears only when its entry leaves without refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            if (ld1)      vld_pipe[1] <= 1'b1;
            else if (ld2) vld_pipe[1] <= 1'b0;
            if (ld2)            vld_pipe[2] <= 1'b1;
            else if (out_ready) vld_pipe[2] <= 1'b0;
        end
    end

    // Stage 1 data: first cross-term sum plus the pass-through corners.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sum <= '0;
            q0_r   <= '0;
            q3_r   <= '0;
        end else if (ld1) begin
            s1_sum <= {s1_c, s1_add};
            q0_r   <= q0;
            q3_r   <= q3;
        end
    end

    // Stage 2 data: the product register, held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      p_r <= '0;
        else if (ld2) p_r <= p_nxt;
    end

    // Completed output handshakes, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         done_count <= '0;
        else if (out_valid && out_ready) done_count <= done_count + 16'd1;
    end

endmodule
